riscv_id_ex_stage: RTL and testbench
====================================

Name: riscv_id_ex_stage

Overview:
- ID/EX pipeline stage that feeds riscv_alu: captures decoded instructions and resolves operand forwarding and load-use hazards.
- Selects ALU source operands and presents registered a, b and alu_ctrl to the ALU.
- Sits between decode and the execute/ALU stage of the 64-bit RISC-V core; valid/ready handshake on both sides.

Parameters:
- WIDTH, 64, datapath width; must equal riscv_alu WIDTH.
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard held and incoming instruction (branch redirect/trap)
- id_valid  in  1  decode holds a valid instruction
- id_ready  out  1  stage accepts on id_valid && id_ready
- id_pc  in  WIDTH  instruction PC
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_rs1_data, id_rs2_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_a_sel  in  2  00 rs1, 01 pc, 10 zero, 11 reserved (treated as zero)
- id_b_sel  in  1  0 rs2, 1 imm
- id_alu_ctrl  in  4  ALU operation code, passed through unchanged
- id_rd_addr  in  5  destination index
- id_we  in  1  writes rd
- id_is_load  in  1  instruction is a load
- ex_ready  in  1  execute stage accepts held instruction
- ex_alu_result  in  WIDTH  combinational ALU output for the held instruction
- exm_we, exm_is_load  in  1  EX/MEM writes rd / is a load whose data is not yet available
- exm_rd  in  5  EX/MEM destination
- exm_data  in  WIDTH  EX/MEM result
- mwb_we  in  1  MEM/WB writes rd
- mwb_rd  in  5  MEM/WB destination
- mwb_data  in  WIDTH  MEM/WB result
- ex_valid  out  1  held instruction valid
- ex_a, ex_b  out  WIDTH  ALU operands
- ex_alu_ctrl  out  4  ALU operation
- ex_store_data  out  WIDTH  forwarded rs2 value (for stores)
- ex_rd_addr  out  5  destination
- ex_we, ex_is_load  out  1  held instruction flags
- stall_cnt  out  CNT_W  hazard-stall cycle count

Behaviour:
- Reset (async, rst=1): every output register is 0, including ex_valid, ex_a, ex_b, ex_alu_ctrl and stall_cnt. id_ready is combinational: it is 0 while hazard=1 and 1 otherwise (ex_valid=0).
- Forwarding per source (rs1, rs2) is evaluated combinationally at capture. Priority, highest first:
  (1) held EX instruction: ex_valid && ex_we && !ex_is_load && ex_rd_addr==rs → ex_alu_result
  (2) exm_we && !exm_is_load && exm_rd==rs → exm_data
  (3) mwb_we && mwb_rd==rs → mwb_data
  (4) id_rsN_data.
- Index 0 never forwards and always yields 0.
- Hazard (load-use): id_valid and rs1 or rs2 (nonzero) matches either (ex_valid && ex_we && ex_is_load && ex_rd_addr) or (exm_we && exm_is_load && exm_rd). Only sources actually used are checked: rs1 when a_sel=00; rs2 when b_sel=0 or id_is_load=0.
- id_ready = !hazard && (!ex_valid || ex_ready).
- Capture: on the clock edge with id_valid && id_ready && !flush, latch operands, controls and forwarded rs2, and set ex_valid=1. Latency is one cycle from acceptance to ex_valid.
- Drain: ex_ready && !capture → ex_valid=0. Held data registers keep their values; consumers ignore them while ex_valid=0.
- Hold: ex_valid && !ex_ready → all outputs stable. Back-to-back accept is allowed when ex_ready=1 (full throughput).
- Flush: ex_valid cleared on the next edge and any simultaneous capture is dropped. Flush has priority over capture and hold.
- stall_cnt increments once per cycle where id_valid && hazard && !flush, and saturates at all-ones (no wrap).
- a_sel=01 uses id_pc; a_sel=10 or 11 gives 0. b_sel=1 uses id_imm. No width conversion is applied; alu_ctrl is passed through unmodified.
- Reset asserted mid-transaction: the held instruction is lost and ex_valid=0 immediately (asynchronous).

Decomposition:
- Shared package (top_defines): A_SEL_RS1/PC/ZERO encodings, B_SEL_RS2/IMM, and ALU control code constants shared with riscv_alu.
- One sub-module, riscv_fwd_mux: a purely combinational 4-way priority forwarding select for a single source index. It is instantiated twice (rs1, rs2).

Test Plan:
- Plain addi x1,x0,5 (imm=5, b_sel=1, a_sel=00, rs1_data=0) → next cycle ex_valid=1, ex_a=0, ex_b=5, ex_alu_ctrl=0000.
- Held add writes x3 with ex_alu_result=0x10; next instruction reads x3 while exm_rd=3 with exm_data=0x20 and mwb_rd=3 with mwb_data=0x30 → ex_a=0x10 (EX has priority).
- Held load writes x5, next instruction uses rs1=5 → id_ready=0 for 1 cycle and stall_cnt=1. When the load is in EX/MEM with exm_is_load=0, the consumer is captured and forwards exm_data.
- Instruction reads x0 while mwb_we=1, mwb_rd=0, mwb_data=0xFF → ex_a=0.
- ex_ready=0 for 3 cycles with ex_valid=1 → outputs unchanged and id_ready=0. Then flush=1 while id_valid=1 → ex_valid=0 next cycle and the incoming instruction is not captured.
- Preload stall_cnt near all-ones (CNT_W=4 build) and apply 20 hazard cycles → stall_cnt holds 0xF. Assert rst mid-hold → ex_valid=0 asynchronously.

Source files
------------

// File: rtl/riscv_id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: operand selects, ALU control codes
// (common with riscv_alu) and the held-control payload.
package riscv_id_ex_stage_pkg;

   localparam int unsigned REG_W      = 5;
   localparam int unsigned ALU_CTRL_W = 4;
   localparam int unsigned A_SEL_W    = 2;

   localparam logic [A_SEL_W-1:0] A_SEL_RS1  = 2'b00;
   localparam logic [A_SEL_W-1:0] A_SEL_PC   = 2'b01;
   localparam logic [A_SEL_W-1:0] A_SEL_ZERO = 2'b10;

   localparam logic B_SEL_RS2 = 1'b0;
   localparam logic B_SEL_IMM = 1'b1;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0101;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b1000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1001;

   typedef struct packed {
      logic [ALU_CTRL_W-1:0] alu_ctrl;
      logic [REG_W-1:0]      rd_addr;
      logic                  we;
      logic                  is_load;
   } ex_ctrl_t;

endpackage

// File: rtl/riscv_id_ex_stage_fwd_mux.sv
// Combinational priority forwarding select for one source register:
// held EX result, then EX/MEM, then MEM/WB, then register file; x0 is always 0.
module riscv_fwd_mux
   import riscv_id_ex_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic [REG_W-1:0] i_rs,
   input  logic [WIDTH-1:0] i_rf_data,
   input  logic             i_ex_fwd_en,
   input  logic [REG_W-1:0] i_ex_rd,
   input  logic [WIDTH-1:0] i_ex_data,
   input  logic             i_exm_we,
   input  logic             i_exm_is_load,
   input  logic [REG_W-1:0] i_exm_rd,
   input  logic [WIDTH-1:0] i_exm_data,
   input  logic             i_mwb_we,
   input  logic [REG_W-1:0] i_mwb_rd,
   input  logic [WIDTH-1:0] i_mwb_data,
   output logic [WIDTH-1:0] o_data_c
);

   always_comb begin
      o_data_c = i_rf_data;
      if (i_rs == '0)
         o_data_c = '0;
      else if (i_ex_fwd_en && (i_ex_rd == i_rs))
         o_data_c = i_ex_data;
      else if (i_exm_we && !i_exm_is_load && (i_exm_rd == i_rs))
         o_data_c = i_exm_data;
      else if (i_mwb_we && (i_mwb_rd == i_rs))
         o_data_c = i_mwb_data;
   end

endmodule

// File: rtl/riscv_id_ex_stage.sv
// ID/EX pipeline register feeding riscv_alu: operand forwarding, load-use
// stall detection, operand select and a saturating stall-cycle counter.
module riscv_id_ex_stage
   import riscv_id_ex_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [WIDTH-1:0]      id_pc,
   input  logic [REG_W-1:0]      id_rs1_addr,
   input  logic [REG_W-1:0]      id_rs2_addr,
   input  logic [WIDTH-1:0]      id_rs1_data,
   input  logic [WIDTH-1:0]      id_rs2_data,
   input  logic [WIDTH-1:0]      id_imm,
   input  logic [A_SEL_W-1:0]    id_a_sel,
   input  logic                  id_b_sel,
   input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
   input  logic [REG_W-1:0]      id_rd_addr,
   input  logic                  id_we,
   input  logic                  id_is_load,
   input  logic                  ex_ready,
   input  logic [WIDTH-1:0]      ex_alu_result,
   input  logic                  exm_we,
   input  logic                  exm_is_load,
   input  logic [REG_W-1:0]      exm_rd,
   input  logic [WIDTH-1:0]      exm_data,
   input  logic                  mwb_we,
   input  logic [REG_W-1:0]      mwb_rd,
   input  logic [WIDTH-1:0]      mwb_data,
   output logic                  ex_valid,
   output logic [WIDTH-1:0]      ex_a,
   output logic [WIDTH-1:0]      ex_b,
   output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
   output logic [WIDTH-1:0]      ex_store_data,
   output logic [REG_W-1:0]      ex_rd_addr,
   output logic                  ex_we,
   output logic                  ex_is_load,
   output logic [CNT_W-1:0]      stall_cnt
);

   logic             r_ex_valid;
   logic [WIDTH-1:0] r_ex_a;
   logic [WIDTH-1:0] r_ex_b;
   logic [WIDTH-1:0] r_ex_store_data;
   ex_ctrl_t         r_ex_ctrl;
   logic [CNT_W-1:0] r_stall_cnt;

   logic             w_ex_fwd_en;
   logic [WIDTH-1:0] w_rs1_fwd;
   logic [WIDTH-1:0] w_rs2_fwd;
   logic             w_ex_ld;
   logic             w_exm_ld;
   logic             w_rs1_hit;
   logic             w_rs2_hit;
   logic             w_use_rs1;
   logic             w_use_rs2;
   logic             w_hazard;
   logic             w_ready;
   logic             w_capture;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;

   assign w_ex_fwd_en = r_ex_valid && r_ex_ctrl.we && !r_ex_ctrl.is_load;

   riscv_fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs1 (
      .i_rs          (id_rs1_addr),
      .i_rf_data     (id_rs1_data),
      .i_ex_fwd_en   (w_ex_fwd_en),
      .i_ex_rd       (r_ex_ctrl.rd_addr),
      .i_ex_data     (ex_alu_result),
      .i_exm_we      (exm_we),
      .i_exm_is_load (exm_is_load),
      .i_exm_rd      (exm_rd),
      .i_exm_data    (exm_data),
      .i_mwb_we      (mwb_we),
      .i_mwb_rd      (mwb_rd),
      .i_mwb_data    (mwb_data),
      .o_data_c      (w_rs1_fwd)
   );

   riscv_fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs2 (
      .i_rs          (id_rs2_addr),
      .i_rf_data     (id_rs2_data),
      .i_ex_fwd_en   (w_ex_fwd_en),
      .i_ex_rd       (r_ex_ctrl.rd_addr),
      .i_ex_data     (ex_alu_result),
      .i_exm_we      (exm_we),
      .i_exm_is_load (exm_is_load),
      .i_exm_rd      (exm_rd),
      .i_exm_data    (exm_data),
      .i_mwb_we      (mwb_we),
      .i_mwb_rd      (mwb_rd),
      .i_mwb_data    (mwb_data),
      .o_data_c      (w_rs2_fwd)
   );

   // Load-use: a pending load in EX or EX/MEM targets a source this instruction reads.
   assign w_ex_ld   = r_ex_valid && r_ex_ctrl.we && r_ex_ctrl.is_load;
   assign w_exm_ld  = exm_we && exm_is_load;
   assign w_rs1_hit = (id_rs1_addr != '0) &&
                      ((w_ex_ld && (r_ex_ctrl.rd_addr == id_rs1_addr)) ||
                       (w_exm_ld && (exm_rd == id_rs1_addr)));
   assign w_rs2_hit = (id_rs2_addr != '0) &&
                      ((w_ex_ld && (r_ex_ctrl.rd_addr == id_rs2_addr)) ||
                       (w_exm_ld && (exm_rd == id_rs2_addr)));
   assign w_use_rs1 = (id_a_sel == A_SEL_RS1);
   assign w_use_rs2 = (id_b_sel == B_SEL_RS2) || !id_is_load;
   assign w_hazard  = id_valid && ((w_use_rs1 && w_rs1_hit) || (w_use_rs2 && w_rs2_hit));

   assign w_ready   = !w_hazard && (!r_ex_valid || ex_ready);
   assign w_capture = id_valid && w_ready && !flush;
   assign id_ready  = w_ready;

   always_comb begin
      w_a = '0;
      case (id_a_sel)
         A_SEL_RS1: w_a = w_rs1_fwd;
         A_SEL_PC:  w_a = id_pc;
         default:   w_a = '0;
      endcase
   end

   assign w_b = (id_b_sel == B_SEL_IMM) ? id_imm : w_rs2_fwd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_valid      <= 1'b0;
         r_ex_a          <= '0;
         r_ex_b          <= '0;
         r_ex_store_data <= '0;
         r_ex_ctrl       <= '0;
      end else if (flush) begin
         r_ex_valid <= 1'b0;
      end else if (w_capture) begin
         r_ex_valid      <= 1'b1;
         r_ex_a          <= w_a;
         r_ex_b          <= w_b;
         r_ex_store_data <= w_rs2_fwd;
         r_ex_ctrl       <= '{alu_ctrl: id_alu_ctrl, rd_addr: id_rd_addr,
                              we: id_we, is_load: id_is_load};
      end else if (ex_ready) begin
         r_ex_valid <= 1'b0;
      end
   end

   // Saturating count of cycles a valid instruction is held back by a load-use hazard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_hazard && !flush && (r_stall_cnt != '1))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign ex_valid      = r_ex_valid;
   assign ex_a          = r_ex_a;
   assign ex_b          = r_ex_b;
   assign ex_alu_ctrl   = r_ex_ctrl.alu_ctrl;
   assign ex_store_data = r_ex_store_data;
   assign ex_rd_addr    = r_ex_ctrl.rd_addr;
   assign ex_we         = r_ex_ctrl.we;
   assign ex_is_load    = r_ex_ctrl.is_load;
   assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// Directed bench for riscv_id_ex_stage: a behavioural pipeline model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_riscv_id_ex_stage;

   localparam int unsigned W    = 64;
   localparam int unsigned CW   = 4;
   localparam int          CMAX = 15;

   logic          clk = 1'b0;
   logic          rst, flush, id_valid, id_ready;
   logic [W-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]    id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [1:0]    id_a_sel;
   logic          id_b_sel, id_we, id_is_load;
   logic [3:0]    id_alu_ctrl;
   logic          ex_ready;
   logic [W-1:0]  ex_alu_result, exm_data, mwb_data;
   logic          exm_we, exm_is_load, mwb_we;
   logic [4:0]    exm_rd, mwb_rd;
   logic          ex_valid, ex_we, ex_is_load;
   logic [W-1:0]  ex_a, ex_b, ex_store_data;
   logic [3:0]    ex_alu_ctrl;
   logic [4:0]    ex_rd_addr;
   logic [CW-1:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   riscv_id_ex_stage #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_ctrl(id_alu_ctrl),
      .id_rd_addr(id_rd_addr), .id_we(id_we), .id_is_load(id_is_load),
      .ex_ready(ex_ready), .ex_alu_result(ex_alu_result),
      .exm_we(exm_we), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
      .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_we(ex_we),
      .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid, m_we, m_ld;
   logic [W-1:0] m_a, m_b, m_sd;
   logic [3:0]  m_ctrl;
   logic [4:0]  m_rd;
   int          m_cnt;

   function automatic logic [W-1:0] m_fwd(input logic [4:0] rs, input logic [W-1:0] rf);
      if (rs == 5'd0) return '0;
      if (m_valid && m_we && !m_ld && m_rd == rs) return ex_alu_result;
      if (exm_we && !exm_is_load && exm_rd == rs) return exm_data;
      if (mwb_we && mwb_rd == rs) return mwb_data;
      return rf;
   endfunction

   function automatic bit m_hazard();
      bit         pend_v [2];
      logic [4:0] pend_rd[2];
      bit         h = 1'b0;
      pend_v[0] = m_valid && m_we && m_ld;  pend_rd[0] = m_rd;
      pend_v[1] = exm_we && exm_is_load;    pend_rd[1] = exm_rd;
      if (!id_valid) return 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (pend_v[i] && pend_rd[i] != 5'd0) begin
            if (id_a_sel == 2'b00 && id_rs1_addr == pend_rd[i]) h = 1'b1;
            if ((id_b_sel == 1'b0 || !id_is_load) && id_rs2_addr == pend_rd[i]) h = 1'b1;
         end
      end
      return h;
   endfunction

   function automatic bit m_ready();
      return !m_hazard() && (!m_valid || ex_ready);
   endfunction

   always @(posedge clk or posedge rst) begin
      logic [W-1:0] na, nb, ns;
      bit hz, rdy;
      if (rst) begin
         m_valid = 0; m_we = 0; m_ld = 0; m_a = '0; m_b = '0; m_sd = '0;
         m_ctrl = '0; m_rd = '0; m_cnt = 0;
      end else begin
         hz  = m_hazard();
         rdy = m_ready();
         if (hz && !flush && m_cnt < CMAX) m_cnt++;
         if (flush) m_valid = 0;
         else if (id_valid && rdy) begin
            na = (id_a_sel == 2'b00) ? m_fwd(id_rs1_addr, id_rs1_data) :
                 (id_a_sel == 2'b01) ? id_pc : '0;
            ns = m_fwd(id_rs2_addr, id_rs2_data);
            nb = id_b_sel ? id_imm : ns;
            m_a = na; m_b = nb; m_sd = ns; m_ctrl = id_alu_ctrl;
            m_rd = id_rd_addr; m_we = id_we; m_ld = id_is_load; m_valid = 1;
         end else if (ex_ready) m_valid = 0;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("id_ready", W'(id_ready), W'(m_ready()));
         chk("ex_valid", W'(ex_valid), W'(m_valid));
         chk("ex_a", ex_a, m_a);
         chk("ex_b", ex_b, m_b);
         chk("ex_alu_ctrl", W'(ex_alu_ctrl), W'(m_ctrl));
         chk("ex_store_data", ex_store_data, m_sd);
         chk("ex_rd_addr", W'(ex_rd_addr), W'(m_rd));
         chk("ex_we", W'(ex_we), W'(m_we));
         chk("ex_is_load", W'(ex_is_load), W'(m_ld));
         chk("stall_cnt", W'(stall_cnt), W'(m_cnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      flush = 0; id_valid = 0; id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0;
      id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_a_sel = 2'b00; id_b_sel = 0;
      id_alu_ctrl = '0; id_rd_addr = '0; id_we = 0; id_is_load = 0;
      ex_ready = 1; ex_alu_result = '0; exm_we = 0; exm_is_load = 0; exm_rd = '0;
      exm_data = '0; mwb_we = 0; mwb_rd = '0; mwb_data = '0;
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [1:0] asel, input logic [4:0] rs1, input logic [W-1:0] rs1d,
                        input logic bsel, input logic [4:0] rs2, input logic [W-1:0] rs2d,
                        input logic [W-1:0] imm, input logic [3:0] ctrl,
                        input logic [4:0] rd, input logic we, input logic ld);
      id_valid = 1; id_a_sel = asel; id_rs1_addr = rs1; id_rs1_data = rs1d;
      id_b_sel = bsel; id_rs2_addr = rs2; id_rs2_data = rs2d; id_imm = imm;
      id_alu_ctrl = ctrl; id_rd_addr = rd; id_we = we; id_is_load = ld;
   endtask

   initial begin
      rst = 1;
      idle();
      repeat (2) clk1();
      chk("rst ex_valid", W'(ex_valid), '0);
      chk("rst ex_a", ex_a, '0);
      chk("rst ex_b", ex_b, '0);
      chk("rst ex_alu_ctrl", W'(ex_alu_ctrl), '0);
      chk("rst stall_cnt", W'(stall_cnt), '0);
      chk("rst id_ready", W'(id_ready), W'(1));
      rst = 0;
      chk_en = 1;

      // addi x1, x0, 5
      instr(2'b00, 5'd0, '0, 1'b1, 5'd0, '0, 64'd5, 4'b0000, 5'd1, 1'b1, 1'b0);
      clk1();
      chk("addi ex_valid", W'(ex_valid), W'(1));
      chk("addi ex_a", ex_a, '0);
      chk("addi ex_b", ex_b, 64'd5);
      chk("addi ex_alu_ctrl", W'(ex_alu_ctrl), '0);

      // add x3, x10, x11 held; consumer of x3 sees EX result over EX/MEM and MEM/WB
      idle();
      instr(2'b00, 5'd10, 64'h7, 1'b0, 5'd11, 64'h9, '0, 4'b0000, 5'd3, 1'b1, 1'b0);
      clk1();
      idle();
      ex_alu_result = 64'h10;
      exm_we = 1; exm_rd = 5'd3; exm_data = 64'h20;
      mwb_we = 1; mwb_rd = 5'd3; mwb_data = 64'h30;
      instr(2'b00, 5'd3, 64'h99, 1'b1, 5'd0, '0, 64'd1, 4'b0001, 5'd4, 1'b1, 1'b0);
      clk1();
      chk("fwd ex prio", ex_a, 64'h10);
      instr(2'b00, 5'd3, 64'h99, 1'b1, 5'd0, '0, 64'd1, 4'b0010, 5'd0, 1'b0, 1'b0);
      clk1();
      chk("fwd exm prio", ex_a, 64'h20);
      exm_we = 0;
      instr(2'b00, 5'd3, 64'h99, 1'b1, 5'd3, 64'h88, 64'd2, 4'b0011, 5'd0, 1'b0, 1'b0);
      clk1();
      chk("fwd mwb a", ex_a, 64'h30);
      chk("fwd mwb store", ex_store_data, 64'h30);
      chk("imm b", ex_b, 64'd2);

      // load x5 held, consumer of x5 stalls one cycle
      idle();
      instr(2'b00, 5'd0, '0, 1'b1, 5'd0, '0, 64'd8, 4'b0000, 5'd5, 1'b1, 1'b1);
      clk1();
      idle();
      instr(2'b00, 5'd5, 64'h1, 1'b1, 5'd0, '0, 64'd1, 4'b0000, 5'd6, 1'b1, 1'b0);
      #1;
      chk("lu id_ready", W'(id_ready), '0);
      clk1();
      chk("lu drained", W'(ex_valid), '0);
      chk("lu stall_cnt", W'(stall_cnt), W'(1));
      exm_we = 1; exm_rd = 5'd5; exm_is_load = 0; exm_data = 64'h55;
      #1;
      chk("lu released", W'(id_ready), W'(1));
      clk1();
      chk("lu captured", W'(ex_valid), W'(1));
      chk("lu fwd exm", ex_a, 64'h55);

      // rs2 hazard depends on whether rs2 is actually used
      idle();
      exm_we = 1; exm_is_load = 1; exm_rd = 5'd7;
      instr(2'b00, 5'd0, '0, 1'b0, 5'd7, '0, '0, 4'b0000, 5'd0, 1'b0, 1'b0);
      #1;
      chk("rs2 alu hazard", W'(id_ready), '0);
      id_b_sel = 1; id_is_load = 1;
      #1;
      chk("rs2 unused", W'(id_ready), W'(1));
      id_is_load = 0;
      #1;
      chk("rs2 store hazard", W'(id_ready), '0);
      clk1();
      chk("rs2 stall_cnt", W'(stall_cnt), W'(2));

      // x0 never forwards; pc and reserved a_sel
      idle();
      mwb_we = 1; mwb_rd = 5'd0; mwb_data = 64'hFF;
      instr(2'b00, 5'd0, 64'hAB, 1'b1, 5'd0, 64'hCD, 64'd2, 4'b0000, 5'd0, 1'b0, 1'b0);
      clk1();
      chk("x0 a", ex_a, '0);
      chk("x0 store", ex_store_data, '0);
      id_a_sel = 2'b01; id_pc = 64'h1000;
      clk1();
      chk("pc a", ex_a, 64'h1000);
      id_a_sel = 2'b11; id_rs1_addr = 5'd1; id_rs1_data = 64'h77;
      clk1();
      chk("rsvd a", ex_a, '0);

      // back-pressure hold, then flush with an incoming instruction
      idle();
      instr(2'b01, 5'd0, '0, 1'b1, 5'd0, '0, 64'h33, 4'b0101, 5'd8, 1'b1, 1'b0);
      id_pc = 64'h200;
      clk1();
      ex_ready = 0;
      instr(2'b01, 5'd0, '0, 1'b1, 5'd0, '0, 64'h44, 4'b0010, 5'd9, 1'b1, 1'b0);
      id_pc = 64'h300;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold id_ready", W'(id_ready), '0);
         clk1();
         chk("hold ex_valid", W'(ex_valid), W'(1));
         chk("hold ex_a", ex_a, 64'h200);
         chk("hold ex_b", ex_b, 64'h33);
         chk("hold ctrl", W'(ex_alu_ctrl), W'(4'b0101));
      end
      flush = 1;
      clk1();
      chk("flush ex_valid", W'(ex_valid), '0);
      idle();
      clk1();
      chk("flush dropped", W'(ex_valid), '0);

      // stall counter: flush blocks counting, then saturation
      exm_we = 1; exm_is_load = 1; exm_rd = 5'd9;
      instr(2'b00, 5'd9, '0, 1'b1, 5'd0, '0, '0, 4'b0000, 5'd0, 1'b0, 1'b0);
      flush = 1;
      clk1();
      chk("flush no count", W'(stall_cnt), W'(2));
      flush = 0;
      repeat (20) clk1();
      chk("stall saturate", W'(stall_cnt), W'(15));

      // asynchronous reset while an instruction is held
      idle();
      instr(2'b01, 5'd0, '0, 1'b1, 5'd0, '0, 64'h1, 4'b0000, 5'd2, 1'b1, 1'b0);
      clk1();
      ex_ready = 0; id_valid = 0;
      chk("pre-rst ex_valid", W'(ex_valid), W'(1));
      #2;
      rst = 1;
      #1;
      chk("async rst ex_valid", W'(ex_valid), '0);
      chk("async rst stall_cnt", W'(stall_cnt), '0);
      repeat (2) clk1();
      rst = 0;
      idle();
      repeat (3) clk1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
